amba_ahb_master: RTL and testbench

Single-initiator AMBA AHB bus master that converts simple commands (address, direction, size, beat count) into AHB NONSEQ/SEQ transfer sequences with correct address/data phase pipelining. It is the initiator counterpart of the `amba_ahb_slave` memory model, sharing its bus signal set, widths and `amba_ahb_defines.sv` encodings. It sits between a test sequencer or DMA-style client and an AHB slave, with no arbiter (`hbusreq`/`hgrant` not used).

---
 rtl/amba_ahb_master.sv | 230 +++++++++++++++++++++++
 tb/tb_amba_ahb_master.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amba_ahb_master.sv
`default_nettype none
// ============================================================================
//  Module   : amba_ahb_master
//  Purpose  : Single-initiator AHB master. Turns a command (address,
//             direction, size, beat count, prot) into a NONSEQ/SEQ transfer
//             sequence with pipelined address and data phases.
//  Options  : AMBA_AHB_MASTER_1KB_SPLIT_EN - restart a burst with NONSEQ
//             when the next beat crosses a 1 KB boundary; such commands use
//             hburst=INCR throughout.
//  Revision : 1.0 - initial release
// ============================================================================
module amba_ahb_master #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int RW = 2,
  parameter int LW = 8
) (
  input  logic          hclk,
  input  logic          hresetn,
  output logic [AW-1:0] haddr,
  output logic [1:0]    htrans,
  output logic          hwrite,
  output logic [2:0]    hsize,
  output logic [2:0]    hburst,
  output logic [3:0]    hprot,
  output logic [DW-1:0] hwdata,
  input  logic [DW-1:0] hrdata,
  input  logic          hready,
  input  logic [RW-1:0] hresp,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic          cmd_write,
  input  logic [2:0]    cmd_size,
  input  logic [LW-1:0] cmd_len,
  input  logic [3:0]    cmd_prot,
  output logic          wr_req,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          done,
  output logic          done_err
);

  localparam logic [1:0]    c_TRANS_IDLE   = 2'b00;
  localparam logic [1:0]    c_TRANS_NONSEQ = 2'b10;
  localparam logic [1:0]    c_TRANS_SEQ    = 2'b11;
  localparam logic [2:0]    c_BURST_SINGLE = 3'b000;
  localparam logic [2:0]    c_BURST_INCR   = 3'b001;
  localparam logic [2:0]    c_BURST_INCR4  = 3'b011;
  localparam logic [2:0]    c_BURST_INCR8  = 3'b101;
  localparam logic [2:0]    c_BURST_INCR16 = 3'b111;
  localparam logic [RW-1:0] c_RESP_OKAY    = RW'(0);
  localparam logic [RW-1:0] c_RESP_ERROR   = RW'(1);
  localparam logic [2:0]    c_MAX_SIZE     = 3'($clog2(DW/8));

  // Each state names what the master currently drives on the bus.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_BURST = 3'd2,
    S_LAST  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [LW-1:0] r_remain;      // address phases still to issue after the current one
  logic          r_dph_valid;   // a data phase is in progress
  logic          r_dph_write;

  logic          w_accept;
  logic          w_reject;
  logic          w_aph;
  logic          w_dph_busy;
  logic          w_err_first;
  logic          w_dph_done;
  logic          w_dph_ok;
  logic          w_dph_bad;
  logic          w_aph_done;
  logic          w_last_beat;
  logic [AW-1:0] w_next_addr;
  logic          w_next_cross;
  logic          w_cmd_cross;

  function automatic logic [2:0] burst_sel(input logic [LW-1:0] len);
    logic [2:0] b;
    case (len)
      LW'(0):  b = c_BURST_SINGLE;
      LW'(3):  b = c_BURST_INCR4;
      LW'(7):  b = c_BURST_INCR8;
      LW'(15): b = c_BURST_INCR16;
      default: b = c_BURST_INCR;
    endcase
    return b;
  endfunction

  assign cmd_ready   = (r_state == S_IDLE);
  assign w_accept    = cmd_valid & cmd_ready;
  assign w_reject    = (cmd_size > c_MAX_SIZE);
  assign w_aph       = (r_state == S_ADDR) | (r_state == S_BURST);
  assign w_dph_busy  = r_dph_valid & (w_aph | (r_state == S_LAST));
  assign w_err_first = w_dph_busy & ~hready & (hresp == c_RESP_ERROR);
  assign w_dph_done  = w_dph_busy & hready;
  assign w_dph_ok    = w_dph_done & (hresp == c_RESP_OKAY);
  assign w_dph_bad   = w_dph_done & (hresp != c_RESP_OKAY);
  assign w_aph_done  = w_aph & hready & ~w_dph_bad;
  assign w_last_beat = (r_remain == '0);
  assign w_next_addr = haddr + (AW'(1) << hsize);
  assign wr_req      = w_aph_done & hwrite;

`ifdef AMBA_AHB_MASTER_1KB_SPLIT_EN
  logic [15:0] w_span_end;
  // Offset of the last beat's start inside the 1 KB page; overflow means a crossing.
  assign w_span_end   = {6'd0, cmd_addr[9:0]} + (16'(cmd_len) << cmd_size);
  assign w_cmd_cross  = (w_span_end[15:10] != 6'd0);
  assign w_next_cross = (w_next_addr[9:0] == 10'd0);
`else
  assign w_cmd_cross  = 1'b0;
  assign w_next_cross = 1'b0;
`endif

  // State register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode; follows address/data phase completions on the bus.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_reject) w_state_nxt = S_ADDR;
      end
      S_ADDR, S_BURST: begin
        if (w_err_first)     w_state_nxt = S_ERR;
        else if (w_dph_bad)  w_state_nxt = S_IDLE;
        else if (w_aph_done) begin
          if (w_last_beat)       w_state_nxt = S_LAST;
          else if (w_next_cross) w_state_nxt = S_ADDR;
          else                   w_state_nxt = S_BURST;
        end
      end
      S_LAST: begin
        if (w_err_first)     w_state_nxt = S_ERR;
        else if (w_dph_done) w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        if (hready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs, beat bookkeeping and client-side pulses.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      haddr       <= '0;
      htrans      <= c_TRANS_IDLE;
      hwrite      <= 1'b0;
      hsize       <= 3'd0;
      hburst      <= c_BURST_SINGLE;
      hprot       <= 4'd0;
      hwdata      <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      done        <= 1'b0;
      done_err    <= 1'b0;
      r_remain    <= '0;
      r_dph_valid <= 1'b0;
      r_dph_write <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      done_err <= 1'b0;
      if (w_accept) begin
        if (w_reject) begin
          done     <= 1'b1;
          done_err <= 1'b1;
        end else begin
          haddr       <= cmd_addr;
          htrans      <= c_TRANS_NONSEQ;
          hwrite      <= cmd_write;
          hsize       <= cmd_size;
          hprot       <= cmd_prot;
          hburst      <= w_cmd_cross ? c_BURST_INCR : burst_sel(cmd_len);
          r_remain    <= cmd_len;
          r_dph_valid <= 1'b0;
        end
      end else if (w_err_first) begin
        // Withdraw any pending SEQ while the slave finishes its ERROR response.
        htrans <= c_TRANS_IDLE;
      end else if (r_state == S_ERR) begin
        if (hready) begin
          done        <= 1'b1;
          done_err    <= 1'b1;
          r_dph_valid <= 1'b0;
        end
      end else if (w_dph_bad) begin
        htrans      <= c_TRANS_IDLE;
        done        <= 1'b1;
        done_err    <= 1'b1;
        r_dph_valid <= 1'b0;
      end else begin
        if (w_dph_ok && !r_dph_write) begin
          rd_valid <= 1'b1;
          rd_data  <= hrdata;
        end
        if (w_aph_done) begin
          if (hwrite) hwdata <= wr_data;
          r_dph_valid <= 1'b1;
          r_dph_write <= hwrite;
          if (w_last_beat) begin
            htrans <= c_TRANS_IDLE;
          end else begin
            haddr    <= w_next_addr;
            r_remain <= r_remain - LW'(1);
            htrans   <= w_next_cross ? c_TRANS_NONSEQ : c_TRANS_SEQ;
          end
        end else if ((r_state == S_LAST) && w_dph_ok) begin
          done        <= 1'b1;
          r_dph_valid <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_amba_ahb_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_amba_ahb_master
//  Purpose  : Directed bench for amba_ahb_master with a small AHB memory
//             slave (programmable wait states and two-cycle ERROR).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_amba_ahb_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RW = 2;
  localparam int LW = 8;
  localparam logic [31:0] c_STEP   = 32'h0101_0101;
  localparam logic [1:0]  c_IDLE   = 2'b00;
  localparam logic [1:0]  c_NONSEQ = 2'b10;
  localparam logic [1:0]  c_SEQ    = 2'b11;
  localparam logic [2:0]  c_SINGLE = 3'b000;
  localparam logic [2:0]  c_INCR   = 3'b001;
  localparam logic [2:0]  c_INCR4  = 3'b011;
  localparam logic [2:0]  c_INCR8  = 3'b101;
  localparam logic [2:0]  c_INCR16 = 3'b111;

  logic          hclk = 1'b0;
  logic          hresetn = 1'b0;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [3:0]    hprot;
  logic [DW-1:0] hwdata;
  logic [DW-1:0] hrdata;
  logic          hready;
  logic [RW-1:0] hresp;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic          cmd_write = 1'b0;
  logic [2:0]    cmd_size = 3'd0;
  logic [LW-1:0] cmd_len = '0;
  logic [3:0]    cmd_prot = 4'd0;
  logic          wr_req;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          done;
  logic          done_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 hclk = ~hclk;

  amba_ahb_master #(.AW(AW), .DW(DW), .RW(RW), .LW(LW)) u_dut (
    .hclk(hclk), .hresetn(hresetn),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hprot(hprot), .hwdata(hwdata), .hrdata(hrdata),
    .hready(hready), .hresp(hresp),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_len(cmd_len),
    .cmd_prot(cmd_prot), .wr_req(wr_req), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .done_err(done_err)
  );

  // ---------------- memory slave ----------------
  logic [31:0] mem [0:1023];
  logic        s_act;
  logic        s_write;
  logic [31:0] s_addr;
  logic [3:0]  s_wcnt;
  logic [1:0]  s_errph;
  logic [7:0]  s_bcnt;
  logic [3:0]  cfg_wait = 4'd0;
  logic [7:0]  cfg_err  = 8'hFF;

  always_comb begin
    hready = 1'b1;
    hresp  = 2'b00;
    if (s_act) begin
      if (s_errph == 2'd1)      begin hready = 1'b0; hresp = 2'b01; end
      else if (s_errph == 2'd2) begin hready = 1'b1; hresp = 2'b01; end
      else                      hready = (s_wcnt == 4'd0);
    end
  end

  assign hrdata = s_act ? mem[s_addr[11:2]] : '0;

  always @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      s_act <= 1'b0; s_write <= 1'b0; s_addr <= '0;
      s_wcnt <= '0; s_errph <= '0; s_bcnt <= '0;
    end else begin
      if (cmd_valid && cmd_ready) s_bcnt <= '0;
      if (hready) begin
        if (htrans[1]) begin
          s_act   <= 1'b1;
          s_addr  <= haddr;
          s_write <= hwrite;
          s_wcnt  <= cfg_wait;
          s_errph <= (s_bcnt == cfg_err) ? 2'd1 : 2'd0;
          s_bcnt  <= s_bcnt + 8'd1;
        end else begin
          s_act   <= 1'b0;
          s_errph <= 2'd0;
        end
      end else if (s_errph == 2'd1) begin
        s_errph <= 2'd2;
      end else if (s_wcnt != 4'd0) begin
        s_wcnt <= s_wcnt - 4'd1;
      end
    end
  end

  always @(posedge hclk) begin
    if (hready && s_act && s_write && (s_errph == 2'd0)) mem[s_addr[11:2]] <= hwdata;
  end

  // ---------------- write-data source ----------------
  logic [31:0] wbeat;
  logic [31:0] wbase = '0;
  logic [31:0] wseed = '0;
  always @(posedge hclk or negedge hresetn) begin
    if (!hresetn)    wbeat <= '0;
    else if (wr_req) wbeat <= wbeat + 32'd1;
  end
  assign wr_data = wseed + (wbeat - wbase) * c_STEP;

  // ---------------- vectors ----------------
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [7:0]  len;
    logic [31:0] seed;
    logic [3:0]  waits;
    logic [7:0]  err_beat;
    int          exp_nrd;
    int          exp_naph;
    logic        exp_err;
    logic [2:0]  exp_burst;
    int          exp_lat;   // negedges after the accept edge until done is seen
  } vec_t;

  localparam int NV = 14;
  vec_t        vecs [NV];
  logic [31:0] ref_mem [0:1023];

  function automatic vec_t mk(input logic [31:0] a, input logic w, input logic [2:0] sz,
                              input logic [7:0] l, input logic [31:0] sd, input logic [3:0] ws,
                              input logic [7:0] eb, input int nrd, input int naph,
                              input logic er, input logic [2:0] bu, input int lat);
    vec_t v;
    v.addr = a; v.wr = w; v.size = sz; v.len = l; v.seed = sd; v.waits = ws;
    v.err_beat = eb; v.exp_nrd = nrd; v.exp_naph = naph; v.exp_err = er;
    v.exp_burst = bu; v.exp_lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_cmd(input vec_t v, input logic [3:0] prot);
    int          cyc, naph, nrd, pw;
    logic        prev_err, prev_wait, seen;
    logic [31:0] snap_addr, snap_wdata, ea;
    logic [1:0]  snap_trans, et;
    logic [9:0]  idx;
    cyc = 0; naph = 0; nrd = 0; pw = -1;
    prev_err = 1'b0; prev_wait = 1'b0; seen = 1'b0;
    snap_addr = '0; snap_wdata = '0; snap_trans = '0;
    @(negedge hclk);
    cfg_wait = v.waits; cfg_err = v.err_beat; wseed = v.seed; wbase = wbeat;
    cmd_valid = 1'b1; cmd_addr = v.addr; cmd_write = v.wr; cmd_size = v.size;
    cmd_len = v.len; cmd_prot = prot;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    if (v.wr && v.size <= 3'd2) begin
      for (int k = 0; k <= int'(v.len); k++) begin
        idx = 10'((v.addr >> 2) + 32'(k));
        ref_mem[idx] = v.seed + 32'(k) * c_STEP;
      end
    end
    @(posedge hclk);
    while (!seen && cyc < 200) begin
      @(negedge hclk);
      cmd_valid = 1'b0;
      if (cyc == 0 && v.exp_lat != 0) chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
      if (prev_err) chk("htrans_idle_after_err", 64'(htrans), 64'(c_IDLE));
      if (prev_wait) begin
        chk("hold_haddr", 64'(haddr), 64'(snap_addr));
        chk("hold_htrans", 64'(htrans), 64'(snap_trans));
        chk("hold_hwdata", 64'(hwdata), 64'(snap_wdata));
      end
      if (!hready) chk("wr_req_in_wait", 64'(wr_req), 64'd0);
      if (rd_valid) begin
        idx = 10'((v.addr >> 2) + 32'(nrd));
        chk("rd_data", 64'(rd_data), 64'(ref_mem[idx]));
        nrd++;
      end
      if (pw >= 0 && hready && hresp == 2'b00) begin
        chk("hwdata", 64'(hwdata), 64'(v.seed + 32'(pw) * c_STEP));
        pw = -1;
      end
      if (hready && htrans[1]) begin
        ea = v.addr + (32'(naph) << v.size);
        et = (naph == 0) ? c_NONSEQ : c_SEQ;
`ifdef AMBA_AHB_MASTER_1KB_SPLIT_EN
        if (ea[9:0] == 10'd0) et = c_NONSEQ;
`endif
        chk("haddr", 64'(haddr), 64'(ea));
        chk("htrans", 64'(htrans), 64'(et));
        chk("hburst", 64'(hburst), 64'(v.exp_burst));
        chk("hwrite", 64'(hwrite), 64'(v.wr));
        chk("hsize", 64'(hsize), 64'(v.size));
        chk("hprot", 64'(hprot), 64'(prot));
        if (v.wr) pw = naph;
        naph++;
      end
      prev_err   = (hresp == 2'b01) && !hready;
      prev_wait  = !hready && (hresp == 2'b00);
      snap_addr  = haddr; snap_trans = htrans; snap_wdata = hwdata;
      if (done) begin
        seen = 1'b1;
        chk("done_latency", 64'(cyc), 64'(v.exp_lat));
        chk("done_err", 64'(done_err), 64'(v.exp_err));
        chk("rd_valid_count", 64'(nrd), 64'(v.exp_nrd));
        chk("addr_phase_count", 64'(naph), 64'(v.exp_naph));
        chk("cmd_ready_at_done", 64'(cmd_ready), 64'd1);
      end else begin
        cyc++;
      end
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic seen;
    //              addr      wr    sz   len    seed           ws   err    nrd naph er  burst     lat
    vecs[0]  = mk(32'h010, 1'b1, 3'd2, 8'd0,  32'hA5A5_5A5A, 4'd0, 8'hFF, 0,  1,  0, c_SINGLE, 2);
    vecs[1]  = mk(32'h020, 1'b1, 3'd2, 8'd3,  32'h1122_3344, 4'd0, 8'hFF, 0,  4,  0, c_INCR4,  5);
    vecs[2]  = mk(32'h020, 1'b0, 3'd2, 8'd3,  32'h0,         4'd0, 8'hFF, 4,  4,  0, c_INCR4,  5);
    vecs[3]  = mk(32'h020, 1'b0, 3'd2, 8'd1,  32'h0,         4'd2, 8'hFF, 2,  2,  0, c_INCR,   7);
    vecs[4]  = mk(32'h100, 1'b1, 3'd2, 8'd7,  32'hC0DE_0000, 4'd0, 8'hFF, 0,  8,  0, c_INCR8,  9);
    vecs[5]  = mk(32'h100, 1'b0, 3'd2, 8'd7,  32'h0,         4'd0, 8'd1,  1,  2,  1, c_INCR8,  4);
    vecs[6]  = mk(32'h040, 1'b0, 3'd3, 8'd0,  32'h0,         4'd0, 8'hFF, 0,  0,  1, c_SINGLE, 0);
    vecs[7]  = mk(32'h200, 1'b1, 3'd2, 8'd15, 32'h5A00_0000, 4'd1, 8'hFF, 0,  16, 0, c_INCR16, 33);
    vecs[8]  = mk(32'h200, 1'b0, 3'd2, 8'd15, 32'h0,         4'd0, 8'hFF, 16, 16, 0, c_INCR16, 17);
    vecs[9]  = mk(32'h010, 1'b0, 3'd2, 8'd0,  32'h0,         4'd1, 8'hFF, 1,  1,  0, c_SINGLE, 3);
    vecs[10] = mk(32'h300, 1'b1, 3'd2, 8'd4,  32'h00F0_0000, 4'd0, 8'hFF, 0,  5,  0, c_INCR,   6);
    vecs[11] = mk(32'h300, 1'b0, 3'd2, 8'd4,  32'h0,         4'd0, 8'hFF, 5,  5,  0, c_INCR,   6);
`ifdef AMBA_AHB_MASTER_1KB_SPLIT_EN
    vecs[12] = mk(32'h3F8, 1'b1, 3'd2, 8'd3,  32'h7700_0000, 4'd0, 8'hFF, 0,  4,  0, c_INCR,   5);
    vecs[13] = mk(32'h3F8, 1'b0, 3'd2, 8'd3,  32'h0,         4'd0, 8'hFF, 4,  4,  0, c_INCR,   5);
`else
    vecs[12] = mk(32'h3F8, 1'b1, 3'd2, 8'd3,  32'h7700_0000, 4'd0, 8'hFF, 0,  4,  0, c_INCR4,  5);
    vecs[13] = mk(32'h3F8, 1'b0, 3'd2, 8'd3,  32'h0,         4'd0, 8'hFF, 4,  4,  0, c_INCR4,  5);
`endif

    // Reset values while hresetn is held low.
    #2;
    chk("rst_htrans", 64'(htrans), 64'(c_IDLE));
    chk("rst_hburst", 64'(hburst), 64'(c_SINGLE));
    chk("rst_haddr", 64'(haddr), 64'd0);
    chk("rst_hwrite", 64'(hwrite), 64'd0);
    chk("rst_hsize", 64'(hsize), 64'd0);
    chk("rst_hprot", 64'(hprot), 64'd0);
    chk("rst_hwdata", 64'(hwdata), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_done_err", 64'(done_err), 64'd0);
    chk("rst_wr_req", 64'(wr_req), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    repeat (3) @(negedge hclk);
    hresetn = 1'b1;

    for (int i = 0; i < NV; i++) run_cmd(vecs[i], 4'(i));

    // Reset in the middle of a long write burst: everything clears at once
    // and the abandoned command never reports done.
    @(negedge hclk);
    cfg_wait = 4'd1; cfg_err = 8'hFF; wseed = 32'hDEAD_0000; wbase = wbeat;
    cmd_valid = 1'b1; cmd_addr = 32'h280; cmd_write = 1'b1; cmd_size = 3'd2;
    cmd_len = 8'd15; cmd_prot = 4'hF;
    @(posedge hclk);
    @(negedge hclk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge hclk);
    chk("busy_before_reset", 64'(htrans[1]), 64'd1);
    hresetn = 1'b0;
    #1;
    chk("midrst_htrans", 64'(htrans), 64'(c_IDLE));
    chk("midrst_haddr", 64'(haddr), 64'd0);
    chk("midrst_hburst", 64'(hburst), 64'(c_SINGLE));
    chk("midrst_hwrite", 64'(hwrite), 64'd0);
    chk("midrst_hwdata", 64'(hwdata), 64'd0);
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("midrst_wr_req", 64'(wr_req), 64'd0);
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge hclk);
      if (done || htrans != c_IDLE) seen = 1'b1;
    end
    chk("no_activity_after_reset", 64'(seen), 64'd0);

    // The master must accept and complete work again after the reset.
    run_cmd(vecs[9], 4'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
